// File: rtl/sprite_frame_commit_if.sv
// Avalon-MM slave bus between the HPS bridge and the sprite commit controller.
// Reads return registered data one cycle later; the slave never stalls.
interface sprite_frame_commit_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [8:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect, write, read, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write, read, address, writedata,
      output readdata
   );
endinterface

// File: rtl/sprite_frame_commit.sv
// Tear-free sprite position/enable registers: host writes go to shadow copies and an
// armed commit moves them to active at vblank start, one sprite per cycle (NSPR+1 cycles).
module sprite_frame_commit #(
   parameter int NSPR    = 6,
   parameter int VACTIVE = 480
) (
   input  logic                 clk,
   input  logic                 reset,
   sprite_frame_commit_if.slave bus,
   input  logic [9:0]           vcount,
   output logic [NSPR*11-1:0]   act_x,
   output logic [NSPR*10-1:0]   act_y,
   output logic [NSPR-1:0]      act_en,
   output logic                 commit_busy,
   output logic                 irq
);

   localparam int IDXW = $clog2(NSPR + 1);

   localparam logic [8:0] ADDR_EN     = 9'h040;
   localparam logic [8:0] ADDR_CTRL   = 9'h041;
   localparam logic [8:0] ADDR_STATUS = 9'h042;
   localparam logic [8:0] ADDR_FRAME  = 9'h043;

   typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              pending_q, pending_d;
   logic              copy_spr, copy_last;

   logic [10:0]       sh_x [NSPR];
   logic [9:0]        sh_y [NSPR];
   logic [NSPR-1:0]   sh_en;
   logic [10:0]       act_x_r [NSPR];
   logic [9:0]        act_y_r [NSPR];
   logic [NSPR-1:0]   act_en_r;
   logic              auto_q;
   logic              irq_q;
   logic [15:0]       frame_q;
   logic              at_vactive_q;
   logic [31:0]       rdata_q;
   logic [31:0]       rd_mux;

   logic wr_en, rd_en, commit_req, irq_clr, at_vactive, vblank_start;

   assign wr_en      = bus.chipselect & bus.write;
   assign rd_en      = bus.chipselect & bus.read;
   assign commit_req = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[0];
   assign irq_clr    = wr_en && (bus.address == ADDR_STATUS) && bus.writedata[2];

   // Edge-detect the line compare so a held vcount yields a single pulse.
   assign at_vactive   = (vcount == 10'(VACTIVE));
   assign vblank_start = at_vactive & ~at_vactive_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      copy_spr  = 1'b0;
      copy_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (commit_req || (vblank_start && auto_q))
               state_d = ARMED;
         end
         ARMED: begin
            if (vblank_start) begin
               state_d = COPY;
               idx_d   = '0;
            end
         end
         COPY: begin
            if (idx_q == IDXW'(NSPR)) begin
               copy_last = 1'b1;
               pending_d = 1'b0;
               idx_d     = '0;
               state_d   = (pending_q || commit_req || auto_q) ? ARMED : IDLE;
            end else begin
               copy_spr = 1'b1;
               idx_d    = idx_q + 1'b1;
               if (commit_req)
                  pending_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Copies read the pre-edge shadow, so a same-cycle host write lands in the next commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSPR; i++) begin
            sh_x[i]    <= '0;
            sh_y[i]    <= '0;
            act_x_r[i] <= '0;
            act_y_r[i] <= '0;
         end
         sh_en        <= '0;
         act_en_r     <= '0;
         auto_q       <= 1'b0;
         irq_q        <= 1'b0;
         frame_q      <= '0;
         at_vactive_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         at_vactive_q <= at_vactive;
         for (int i = 0; i < NSPR; i++) begin
            if (wr_en && (bus.address == 9'(2 * i)))
               sh_x[i] <= bus.writedata[10:0];
            if (wr_en && (bus.address == 9'(2 * i + 1)))
               sh_y[i] <= bus.writedata[9:0];
            if (copy_spr && (idx_q == IDXW'(i))) begin
               act_x_r[i] <= sh_x[i];
               act_y_r[i] <= sh_y[i];
            end
         end
         if (wr_en && (bus.address == ADDR_EN))
            sh_en <= bus.writedata[NSPR-1:0];
         if (wr_en && (bus.address == ADDR_CTRL))
            auto_q <= bus.writedata[1];
         if (copy_last)
            act_en_r <= sh_en;
         if (copy_last)
            irq_q <= 1'b1;
         else if (irq_clr)
            irq_q <= 1'b0;
         if (vblank_start)
            frame_q <= frame_q + 16'd1;
         if (rd_en)
            rdata_q <= rd_mux;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NSPR; i++) begin
         if (bus.address == 9'(2 * i))
            rd_mux = {21'b0, sh_x[i]};
         if (bus.address == 9'(2 * i + 1))
            rd_mux = {22'b0, sh_y[i]};
      end
      case (bus.address)
         ADDR_EN:     rd_mux = 32'(sh_en);
         ADDR_CTRL:   rd_mux = {30'b0, auto_q, 1'b0};
         ADDR_STATUS: rd_mux = {29'b0, irq_q, (state_q == COPY), (state_q == ARMED)};
         ADDR_FRAME:  rd_mux = {16'b0, frame_q};
         default: ;
      endcase
   end

   always_comb begin
      act_x = '0;
      act_y = '0;
      for (int i = 0; i < NSPR; i++) begin
         act_x[11*i +: 11] = act_x_r[i];
         act_y[10*i +: 10] = act_y_r[i];
      end
   end

   assign act_en      = act_en_r;
   assign commit_busy = (state_q == COPY);
   assign irq         = irq_q;
   assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_sprite_frame_commit.sv
// Randomized + directed bench for sprite_frame_commit: a frame-level reference model fills a
// scoreboard queue that a separate monitor drains on every read response and state probe.
module tb_sprite_frame_commit;
   localparam int NSPR    = 6;
   localparam int VACTIVE = 480;
   localparam int XW      = NSPR * 11;
   localparam int YW      = NSPR * 10;

   logic            clk = 1'b0;
   logic            reset;
   logic [9:0]      vcount;
   logic [XW-1:0]   act_x;
   logic [YW-1:0]   act_y;
   logic [NSPR-1:0] act_en;
   logic            commit_busy;
   logic            irq;

   sprite_frame_commit_if bus();

   sprite_frame_commit #(.NSPR(NSPR), .VACTIVE(VACTIVE)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .vcount      (vcount),
      .act_x       (act_x),
      .act_y       (act_y),
      .act_en      (act_en),
      .commit_busy (commit_busy),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              is_rd;
      bit              chk_tot;
      string           name;
      logic [31:0]     rd;
      logic [XW-1:0]   x;
      logic [YW-1:0]   y;
      logic [NSPR-1:0] en;
      logic            irq;
      logic            busy;
      int              tot;
   } item_t;

   item_t sb[$];
   int    tests = 0;
   int    fails = 0;
   int    busy_tot = 0;
   bit    probe = 1'b0;
   bit    imm_probe = 1'b0;

   // Reference model: what the host has written and what the renderer should see.
   logic [10:0]     m_sx [NSPR];
   logic [9:0]      m_sy [NSPR];
   logic [10:0]     m_ax [NSPR];
   logic [9:0]      m_ay [NSPR];
   logic [NSPR-1:0] m_sen, m_aen;
   bit              m_irq, m_auto, m_armed, m_pending;
   logic [15:0]     m_frame;
   int              m_busy = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSPR; i++) begin
         m_sx[i] = '0; m_sy[i] = '0; m_ax[i] = '0; m_ay[i] = '0;
      end
      m_sen = '0; m_aen = '0; m_irq = 0; m_auto = 0; m_armed = 0; m_pending = 0;
      m_frame = '0;
   endtask

   task automatic model_write(input logic [8:0] a, input logic [31:0] d,
                              input bit in_copy, input bit set_now);
      int s;
      s = int'(a) / 2;
      if (int'(a) < 2 * NSPR) begin
         if (a[0]) m_sy[s] = d[9:0];
         else      m_sx[s] = d[10:0];
      end else begin
         case (a)
            9'h040: m_sen = d[NSPR-1:0];
            9'h041: begin
               m_auto = d[1];
               if (d[0]) begin
                  if (in_copy) m_pending = 1;
                  else         m_armed = 1;
               end
            end
            9'h042: if (d[2] && !set_now) m_irq = 0;
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] model_read(input logic [8:0] a);
      int s;
      s = int'(a) / 2;
      if (int'(a) < 2 * NSPR) return a[0] ? {22'b0, m_sy[s]} : {21'b0, m_sx[s]};
      case (a)
         9'h040:  return 32'(m_sen);
         9'h041:  return {30'b0, m_auto, 1'b0};
         9'h042:  return {29'b0, m_irq, 1'b0, m_armed};
         9'h043:  return {16'b0, m_frame};
         default: return 32'd0;
      endcase
   endfunction

   function automatic item_t snap(input string nm, input bit tot, input bit busy);
      item_t it;
      it.is_rd = 0; it.chk_tot = tot; it.name = nm; it.rd = '0;
      it.x = '0; it.y = '0;
      for (int i = 0; i < NSPR; i++) begin
         it.x[11*i +: 11] = m_ax[i];
         it.y[10*i +: 10] = m_ay[i];
      end
      it.en = m_aen; it.irq = m_irq; it.busy = busy; it.tot = m_busy;
      return it;
   endfunction

   task automatic pop_check(input bit rd);
      item_t it;
      if (sb.size() == 0) begin
         tests++; fails++;
         $display("FAIL sb_underflow: got empty queue expected an item");
      end else begin
         it = sb.pop_front();
         if (it.is_rd != rd) begin
            tests++; fails++;
            $display("FAIL sb_order %s: got kind %0d expected kind %0d", it.name, rd, it.is_rd);
         end else if (rd) begin
            chk(it.name, bus.readdata, it.rd);
         end else begin
            chk({it.name, "_x"}, act_x, it.x);
            chk({it.name, "_y"}, act_y, it.y);
            chk({it.name, "_en"}, act_en, it.en);
            chk({it.name, "_irq"}, irq, it.irq);
            chk({it.name, "_busy"}, commit_busy, it.busy);
            if (it.chk_tot) chk({it.name, "_busytot"}, busy_tot, it.tot);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (bus.chipselect === 1'b1 && bus.read === 1'b1) begin
         #1 pop_check(1);
      end else if (probe) begin
         #1 pop_check(0);
      end
   end

   initial forever begin
      @(posedge imm_probe);
      pop_check(0);
   end

   always @(negedge clk) if (commit_busy === 1'b1) busy_tot++;

   task automatic wr(input logic [8:0] a, input logic [31:0] d);
      bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
      model_write(a, d, 0, 0);
      @(negedge clk);
      bus.chipselect = 0; bus.write = 0;
   endtask

   task automatic rd(input logic [8:0] a, input string nm);
      item_t it;
      it = snap(nm, 0, 0);
      it.is_rd = 1; it.rd = model_read(a);
      sb.push_back(it);
      bus.chipselect = 1; bus.read = 1; bus.address = a;
      @(negedge clk);
      bus.chipselect = 0; bus.read = 0;
   endtask

   task automatic probe_now(input string nm);
      sb.push_back(snap(nm, 1, 0));
      probe = 1;
      @(negedge clk);
      probe = 0;
   endtask

   // One vblank: optional per-cycle probes, one host write at step wk, async reset at step rk.
   task automatic vblank(input bit pc, input int wk, input logic [8:0] wa,
                         input logic [31:0] wd, input int rk);
      bit cp, fin;
      cp = m_armed;
      vcount = 10'(VACTIVE);
      for (int k = 0; k <= NSPR + 1; k++) begin
         if (rk == k) begin
            if (cp) m_busy += k;
            #1 reset = 1; vcount = 10'd0; model_reset();
            #1 sb.push_back(snap("async_rst", 1, 0)); imm_probe = 1;
            #1 imm_probe = 0;
            @(negedge clk); @(negedge clk);
            reset = 0;
            @(negedge clk);
            return;
         end
         fin = cp && (k == NSPR + 1);
         if (k == 0) begin
            m_frame++;
            if (!cp && m_auto) m_armed = 1;
         end
         if (cp && k >= 1 && k <= NSPR) begin
            m_ax[k-1] = m_sx[k-1];
            m_ay[k-1] = m_sy[k-1];
         end
         if (fin) begin
            m_aen = m_sen;
            m_irq = 1;
         end
         if (wk == k) begin
            bus.chipselect = 1; bus.write = 1; bus.address = wa; bus.writedata = wd;
            model_write(wa, wd, cp && k >= 1, fin);
         end
         if (fin) begin
            m_armed = m_auto || m_pending;
            m_pending = 0;
            m_busy += NSPR + 1;
         end
         if (pc) begin
            sb.push_back(snap($sformatf("copy_k%0d", k), 0, cp && k <= NSPR));
            probe = 1;
         end
         @(negedge clk);
         bus.chipselect = 0; bus.write = 0; probe = 0;
      end
      repeat (3) @(negedge clk);
      vcount = 10'($urandom_range(0, VACTIVE - 1));
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, op;
      logic [8:0] a;
      reset = 1; vcount = 10'd0;
      bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);

      probe_now("reset");
      rd(9'h043, "rst_frame");
      rd(9'h042, "rst_status");
      rd(9'h041, "rst_ctrl");

      // Uncommitted write survives two frames without reaching active.
      wr(9'd4, 32'd640);
      vblank(0, -1, '0, '0, -1);
      vblank(0, -1, '0, '0, -1);
      probe_now("nocommit");
      rd(9'h043, "frame_after2");
      rd(9'd4, "shadow_x2");

      wr(9'h041, 32'h1);
      rd(9'h042, "status_armed");
      rd(9'h050, "unmapped");

      wr(9'd0, 32'd100); wr(9'd1, 32'd200); wr(9'h040, 32'h1);
      probe_now("before_vbl");
      vblank(1, -1, '0, '0, -1);
      rd(9'h042, "status_irq");

      // irq clear in the final copy cycle loses to the set.
      wr(9'h041, 32'h1);
      vblank(0, NSPR + 1, 9'h042, 32'h4, -1);
      rd(9'h042, "set_wins");
      wr(9'h042, 32'h4);
      rd(9'h042, "irq_cleared");

      // Commit during COPY re-arms for the next frame.
      wr(9'd2, 32'd321);
      wr(9'h041, 32'h1);
      vblank(0, 2, 9'h041, 32'h1, -1);
      rd(9'h042, "rearmed");
      wr(9'd3, 32'd77);
      vblank(1, -1, '0, '0, -1);
      probe_now("second_commit");

      // Writes landing mid-COPY: behind the copy pointer, at it, ahead of it.
      wr(9'h041, 32'h1);
      vblank(0, 3, 9'd2, 32'd11, -1);
      probe_now("wr_behind");
      wr(9'h041, 32'h1);
      vblank(0, 3, 9'd4, 32'd33, -1);
      probe_now("wr_same");
      wr(9'h041, 32'h1);
      vblank(0, 3, 9'd8, 32'd55, -1);
      probe_now("wr_ahead");

      // Auto-commit: each write shows up on the frame after it is armed.
      wr(9'h042, 32'h4);
      wr(9'h041, 32'h2);
      wr(9'd0, 32'd5);
      vblank(0, -1, '0, '0, -1);
      probe_now("auto_arm");
      vblank(0, -1, '0, '0, -1);
      probe_now("auto_x5");
      wr(9'd0, 32'd9);
      vblank(0, -1, '0, '0, -1);
      probe_now("auto_x9");
      rd(9'h042, "auto_status");
      wr(9'h042, 32'h4);
      rd(9'h042, "auto_irqclr");
      wr(9'h041, 32'h0);
      vblank(0, -1, '0, '0, -1);
      rd(9'h042, "auto_off");

      for (int it = 0; it < 14; it++) begin
         n = $urandom_range(1, 5);
         for (int j = 0; j < n; j++) begin
            op = $urandom_range(0, 6);
            case (op)
               0, 1: wr(9'($urandom_range(0, 2 * NSPR - 1)), $urandom);
               2:    wr(9'h040, $urandom);
               3:    wr(9'h041, 32'($urandom_range(0, 3)));
               4:    wr(9'h042, $urandom);
               5:    wr(9'($urandom_range(0, 511)), $urandom);
               default: begin
                  a = 9'($urandom_range(0, 'h50));
                  rd(a, $sformatf("rnd_rd_%0h", a));
               end
            endcase
         end
         vblank(0, -1, '0, '0, -1);
         probe_now($sformatf("rnd_frame%0d", it));
         rd(9'h043, "rnd_framecnt");
      end

      // Async reset in the middle of a copy discards everything.
      wr(9'h042, 32'h4);
      wr(9'h041, 32'h1);
      vblank(1, -1, '0, '0, 3);
      probe_now("post_reset");
      rd(9'h043, "post_reset_frame");
      rd(9'h042, "post_reset_status");

      repeat (3) @(negedge clk);
      chk("sb_drain", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
